// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single unified memory port: zero-latency
// round-robin grant, one outstanding read, read data steered back to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wmask,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,

  input  logic                aux_req,
  input  logic                aux_we,
  input  logic [ADDR_W-1:0]   aux_addr,
  input  logic [DATA_W-1:0]   aux_wdata,
  input  logic [DATA_W/8-1:0] aux_wmask,
  output logic                aux_gnt,
  output logic                aux_rvalid,
  output logic [DATA_W-1:0]   aux_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  // Counter covers READ_LATENCY-1 for the legal range 1..4.
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic { ARB, RD_WAIT } state_t;
  typedef enum logic { SRC_CORE, SRC_AUX } src_t;

  state_t           state;
  src_t             last_grant;
  src_t             owner;
  logic [CNT_W-1:0] count;

  src_t winner;
  logic grant_any;
  logic rd_done;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner = SRC_CORE;
    if (core_req && aux_req) begin
      winner = (last_grant == SRC_AUX) ? SRC_CORE : SRC_AUX;
    end else if (aux_req) begin
      winner = SRC_AUX;
    end
  end

  assign grant_any = (state == ARB) && (core_req || aux_req);

  assign core_gnt  = grant_any && (winner == SRC_CORE);
  assign aux_gnt   = grant_any && (winner == SRC_AUX);

  assign mem_en    = grant_any;
  assign mem_we    = grant_any && ((winner == SRC_AUX) ? aux_we : core_we);
  assign mem_addr  = aux_gnt ? aux_addr  : core_addr;
  assign mem_wdata = aux_gnt ? aux_wdata : core_wdata;
  assign mem_wmask = aux_gnt ? aux_wmask : core_wmask;

  assign rd_done     = (state == RD_WAIT) && (count == '0);
  assign core_rvalid = rd_done && (owner == SRC_CORE);
  assign aux_rvalid  = rd_done && (owner == SRC_AUX);
  assign core_rdata  = mem_rdata;
  assign aux_rdata   = mem_rdata;

  assign busy = (state == RD_WAIT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      count      <= '0;
      last_grant <= SRC_AUX;
      owner      <= SRC_CORE;
    end else begin
      case (state)
        ARB: begin
          if (grant_any) begin
            last_grant <= winner;
            if (!mem_we) begin
              owner <= winner;
              count <= CNT_LOAD;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Read data arrives in the cycle the counter is already at zero.
          if (count == '0) begin
            state <= ARB;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a rule-level model predicts grants and
// read returns; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = DATA_W / 8;
  localparam int RL        = 3;
  localparam int MEM_WORDS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              core_req, core_we, core_gnt, core_rvalid;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic [MASK_W-1:0] core_wmask;
  logic              aux_req, aux_we, aux_gnt, aux_rvalid;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata, aux_rdata;
  logic [MASK_W-1:0] aux_wmask;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wmask(core_wmask), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_wmask(aux_wmask), .aux_gnt(aux_gnt),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct {
    int                cyc;
    bit                aux;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } gnt_exp_t;

  typedef struct {
    int                cyc;
    bit                aux;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  typedef struct {
    bit                valid;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } cmd_t;

  gnt_exp_t exp_gnt[$];
  rd_exp_t  exp_rd[$];
  cmd_t     core_cmd, aux_cmd;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  int m_remaining = 0;
  bit m_last_aux  = 1'b1;
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];

  logic [DATA_W-1:0]    ram [MEM_WORDS];
  logic [MEM_WORDS-1:0] written = '0;
  logic [DATA_W-1:0]    rd_pipe [RL];

  function automatic int widx(logic [ADDR_W-1:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [DATA_W-1:0] init_val(int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'h3C00_0000 ^ (i * 32'h0001_0203));
  endfunction

  function automatic logic [DATA_W-1:0] merge(logic [DATA_W-1:0] old_w,
                                              logic [DATA_W-1:0] new_w,
                                              logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < MASK_W; k++) if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h, expected nothing at cycle %0d", name, act, cyc);
  endtask

  // Behavioural memory: reads return data RL cycles after the command.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && !mem_we)
      rd_pipe[0] <= written[widx(mem_addr)] ? ram[widx(mem_addr)] : init_val(widx(mem_addr));
    else
      rd_pipe[0] <= {16'hBAD0, cyc[15:0]};
    if (mem_en && mem_we) begin
      ram[widx(mem_addr)] <= merge(written[widx(mem_addr)] ? ram[widx(mem_addr)]
                                                           : init_val(widx(mem_addr)),
                                   mem_wdata, mem_wmask);
      written[widx(mem_addr)] <= 1'b1;
    end
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Monitor: compare whatever the DUT presents against the head of the queues.
  always @(negedge clk) begin : monitor
    gnt_exp_t g;
    rd_exp_t  r;
    if (!rst_n) begin
      check("reset_quiet", {core_gnt, aux_gnt, core_rvalid, aux_rvalid, mem_en, mem_we, busy}, '0);
    end else begin
      while (exp_gnt.size() > 0 && exp_gnt[0].cyc < cyc) begin
        fail_now("missed_grant", 64'(exp_gnt[0].cyc));
        void'(exp_gnt.pop_front());
      end
      while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
        fail_now("missed_rvalid", 64'(exp_rd[0].cyc));
        void'(exp_rd.pop_front());
      end
      if (core_gnt || aux_gnt || mem_en) begin
        if (exp_gnt.size() == 0 || exp_gnt[0].cyc != cyc) begin
          fail_now("unexpected_grant", {core_gnt, aux_gnt, mem_en});
        end else begin
          g = exp_gnt.pop_front();
          check("gnt_core",  core_gnt, !g.aux);
          check("gnt_aux",   aux_gnt, g.aux);
          check("mem_en",    mem_en, 1);
          check("mem_we",    mem_we, g.we);
          check("mem_addr",  mem_addr, g.addr);
          check("mem_wdata", mem_wdata, g.wdata);
          check("mem_wmask", mem_wmask, g.wmask);
        end
      end
      if (core_rvalid || aux_rvalid) begin
        if (exp_rd.size() == 0 || exp_rd[0].cyc != cyc) begin
          fail_now("unexpected_rvalid", {core_rvalid, aux_rvalid});
        end else begin
          r = exp_rd.pop_front();
          check("rvalid_core", core_rvalid, !r.aux);
          check("rvalid_aux",  aux_rvalid, r.aux);
          check("rdata", r.aux ? aux_rdata : core_rdata, r.data);
          check("busy_at_rvalid", busy, 1);
        end
      end
    end
  end

  task automatic drive();
    core_req   = core_cmd.valid;  core_we   = core_cmd.we;   core_addr = core_cmd.addr;
    core_wdata = core_cmd.wdata;  core_wmask = core_cmd.wmask;
    aux_req    = aux_cmd.valid;   aux_we    = aux_cmd.we;    aux_addr  = aux_cmd.addr;
    aux_wdata  = aux_cmd.wdata;   aux_wmask = aux_cmd.wmask;
  endtask

  // One cycle: drive pending commands, predict from the arbitration rules, advance.
  task automatic step();
    gnt_exp_t g;
    rd_exp_t  r;
    cmd_t     c;
    bit       win_aux;
    drive();
    #1;
    if (m_remaining > 0) begin
      check("busy_wait", busy, 1);
      m_remaining--;
    end else begin
      check("busy_idle", busy, 0);
      if (core_cmd.valid || aux_cmd.valid) begin
        win_aux = (core_cmd.valid && aux_cmd.valid) ? !m_last_aux : aux_cmd.valid;
        c = win_aux ? aux_cmd : core_cmd;
        g = '{cyc, win_aux, c.we, c.addr, c.wdata, c.wmask};
        exp_gnt.push_back(g);
        m_last_aux = win_aux;
        if (c.we) begin
          ref_mem[widx(c.addr)] = merge(ref_mem[widx(c.addr)], c.wdata, c.wmask);
        end else begin
          r = '{cyc + RL, win_aux, ref_mem[widx(c.addr)]};
          exp_rd.push_back(r);
          m_remaining = RL;
        end
        if (win_aux) aux_cmd.valid = 1'b0;
        else         core_cmd.valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    core_cmd.valid = 1'b0;
    aux_cmd.valid  = 1'b0;
    drive();
    rst_n = 1'b0;
    if (m_remaining > 0) begin
      void'(exp_rd.pop_back());
      m_remaining = 0;
    end
    m_last_aux = 1'b1;
    #1;
    check("reset_busy",  busy, 0);
    check("reset_outs",  {core_gnt, aux_gnt, core_rvalid, aux_rvalid, mem_en, mem_we}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic cmd_t mk(bit we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wdata,
                              logic [MASK_W-1:0] wmask);
    cmd_t c;
    c = '{1'b1, we, addr, wdata, wmask};
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom), $urandom & 32'h0000_0FFC, $urandom, 4'($urandom));
  endfunction

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    core_cmd = '{1'b0, 1'b0, '0, '0, '0};
    aux_cmd  = '{1'b0, 1'b0, '0, '0, '0};
    drive();
    @(posedge clk);
    #1;
    do_reset();

    // Core read at 0x10 returns 0xDEADBEEF RL cycles later.
    core_cmd = mk(1'b0, 32'h10, 32'h0, 4'hF);
    step();
    repeat (RL + 1) step();

    // Continuous write contention right after reset: core, aux, core, aux.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!core_cmd.valid) core_cmd = mk(1'b1, 32'h100, 32'hC000_0000 + i, 4'hF);
      if (!aux_cmd.valid)  aux_cmd  = mk(1'b1, 32'h200, 32'hA000_0000 + i, 4'hF);
      step();
    end
    core_cmd.valid = 1'b0;
    aux_cmd.valid  = 1'b0;
    step();

    // Aux read, core request arriving during the wait is granted right after.
    aux_cmd = mk(1'b0, 32'h24, 32'h0, 4'hF);
    step();
    core_cmd = mk(1'b1, 32'h28, 32'h5555_AAAA, 4'hF);
    repeat (RL + 2) step();

    // Reset in the first wait cycle discards the read.
    aux_cmd = mk(1'b0, 32'h30, 32'h0, 4'hF);
    step();
    do_reset();
    core_cmd = mk(1'b1, 32'h34, 32'h1111_1111, 4'hF);
    aux_cmd  = mk(1'b1, 32'h38, 32'h2222_2222, 4'hF);
    repeat (2) step();

    // Partial write, then the port is free the very next cycle.
    core_cmd = mk(1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    step();
    aux_cmd = mk(1'b0, 32'h40, 32'h0, 4'hF);
    repeat (RL + 2) step();

    // Core request withdrawn while aux holds the port.
    aux_cmd = mk(1'b0, 32'h44, 32'h0, 4'hF);
    step();
    core_cmd = mk(1'b0, 32'h48, 32'h0, 4'hF);
    step();
    core_cmd.valid = 1'b0;
    repeat (RL) step();
    core_cmd = mk(1'b1, 32'h4C, 32'h3333_3333, 4'hF);
    aux_cmd  = mk(1'b1, 32'h50, 32'h4444_4444, 4'hF);
    repeat (3) step();

    // Randomized traffic with occasional withdrawals and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (!core_cmd.valid) begin
        if ($urandom_range(0, 2) == 0) core_cmd = rand_cmd();
      end else if ($urandom_range(0, 15) == 0) begin
        core_cmd.valid = 1'b0;
      end
      if (!aux_cmd.valid) begin
        if ($urandom_range(0, 2) == 0) aux_cmd = rand_cmd();
      end else if ($urandom_range(0, 15) == 0) begin
        aux_cmd.valid = 1'b0;
      end
      if (i == 1500) do_reset();
      else step();
    end

    core_cmd.valid = 1'b0;
    aux_cmd.valid  = 1'b0;
    repeat (RL + 2) step();
    check("drain_gnt_queue", 64'(exp_gnt.size()), 0);
    check("drain_rd_queue",  64'(exp_rd.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
